// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the runtime-configurable operand delay line.
package delay_line_pkg;

    localparam int unsigned DATA_W_DEF    = 48;
    localparam int unsigned MAX_DEPTH_DEF = 28;

    typedef struct packed {
        logic                  v;
        logic [DATA_W_DEF-1:0] data;
    } stage_t;

    // Zero means "shortest possible delay"; oversize requests saturate at the physical length.
    function automatic int unsigned clamp_depth(input int unsigned cfg,
                                                input int unsigned max_depth);
        if (cfg == 0) begin
            return 1;
        end else if (cfg > max_depth) begin
            return max_depth;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/delay_line_pipe_stage.sv
// One {valid, data} stage of the delay line with synchronous reset, flush and valid-only clear.
module delay_stage #(
    parameter int unsigned DATA_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clr_v,
    input  logic              en,
    input  logic              d_v,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_v,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q_v    <= 1'b0;
            q_data <= '0;
        end else if (clr_v) begin
            q_v <= 1'b0;
        end else if (en) begin
            q_v    <= d_v;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/delay_line_pipe.sv
// Delay line with per-stage valid, stall, flush, runtime depth selection and occupancy count.
module delay_line_pipe
    import delay_line_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_DEPTH = MAX_DEPTH_DEF,
    parameter int unsigned RST_DEPTH = MAX_DEPTH_DEF,
    parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [DEPTH_W-1:0] depth,
    output logic [DEPTH_W-1:0] occupancy,
    output logic               busy
);

    logic [MAX_DEPTH-1:0] stage_v;
    logic [DATA_W-1:0]    stage_data [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] d_v;
    logic [DATA_W-1:0]    d_data     [MAX_DEPTH];

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] occ_q;
    logic [DEPTH_W-1:0] occ_d;
    logic [DEPTH_W-1:0] eff_depth;
    logic               chg;
    logic               advance;
    logic               tap_v;
    logic [DATA_W-1:0]  tap_data;

    assign eff_depth = DEPTH_W'(clamp_depth(32'(cfg_depth), MAX_DEPTH));

    // A new depth is only safe on an empty window with nothing entering this edge.
    assign chg     = (eff_depth != depth_q) && (occ_q == '0) && !(en && in_valid) && !flush;
    assign advance = en && !chg;

    for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign d_v[i]    = in_valid;
            assign d_data[i] = in_data;
        end else begin : g_body
            assign d_v[i]    = stage_v[i-1];
            assign d_data[i] = stage_data[i-1];
        end

        delay_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .clr_v (chg),
            .en    (advance),
            .d_v   (d_v[i]),
            .d_data(d_data[i]),
            .q_v   (stage_v[i]),
            .q_data(stage_data[i])
        );
    end

    always_comb begin
        tap_v    = 1'b0;
        tap_data = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) begin
                tap_v    = stage_v[i];
                tap_data = stage_data[i];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (advance) begin
            occ_d = occ_q + DEPTH_W'(in_valid) - DEPTH_W'(tap_v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= DEPTH_W'(RST_DEPTH);
            occ_q   <= '0;
        end else begin
            occ_q <= occ_d;
            if (chg) begin
                depth_q <= eff_depth;
            end
        end
    end

    assign out_valid = tap_v;
    assign out_data  = tap_data;
    assign depth     = depth_q;
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_delay_line_pipe.sv
// Scoreboard bench for delay_line_pipe: in-flight entries are queued with their remaining latency.
module tb_delay_line_pipe;

    localparam int DATA_W    = 48;
    localparam int MAX_DEPTH = 28;
    localparam int RST_DEPTH = 28;
    localparam int DEPTH_W   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               flush;
    logic [DEPTH_W-1:0] cfg_depth;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] occupancy;
    logic               busy;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                rem;
    } sb_t;

    sb_t sb[$];
    int  exp_depth = RST_DEPTH;
    int  n_checks  = 0;
    int  n_fail    = 0;

    delay_line_pipe #(
        .DATA_W   (DATA_W),
        .MAX_DEPTH(MAX_DEPTH),
        .RST_DEPTH(RST_DEPTH),
        .DEPTH_W  (DEPTH_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .cfg_depth(cfg_depth),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .depth    (depth),
        .occupancy(occupancy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_clamp(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > MAX_DEPTH) return MAX_DEPTH;
        return cfg;
    endfunction

    task automatic drive(input logic e, input logic f, input logic v, input logic [DATA_W-1:0] d);
        en       = e;
        flush    = f;
        in_valid = v;
        in_data  = d;
    endtask

    // One clock edge: update the reference from the pre-edge inputs, then compare outputs.
    task automatic tick();
        logic exp_v;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            exp_depth = RST_DEPTH;
        end else if (flush) begin
            sb.delete();
        end else if (exp_clamp(int'(cfg_depth)) != exp_depth && sb.size() == 0
                     && !(en && in_valid)) begin
            exp_depth = exp_clamp(int'(cfg_depth));
        end else if (en) begin
            if (sb.size() > 0 && sb[0].rem == 0) void'(sb.pop_front());
            foreach (sb[i]) sb[i].rem = sb[i].rem - 1;
            if (in_valid) sb.push_back('{data: in_data, rem: exp_depth - 1});
        end
        #1;
        exp_v = (sb.size() > 0) && (sb[0].rem == 0);
        check_eq("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) check_eq("out_data", 64'(out_data), 64'(sb[0].data));
        check_eq("occupancy", 64'(occupancy), 64'(sb.size()));
        check_eq("busy", 64'(busy), 64'(sb.size() != 0));
        check_eq("depth", 64'(depth), 64'(exp_depth));
    endtask

    task automatic idle(input int n);
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_depth = 5'd28;
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        tick();
        check_eq("rst_out_data", 64'(out_data), 64'h0);
        rst = 1'b0;

        // Full-length latency with a single entry.
        drive(1'b1, 1'b0, 1'b1, 48'h1);
        tick();
        idle(30);

        // Stall: entry 0xA, one advance, three stalled cycles with a dropped input.
        cfg_depth = 5'd4;
        idle(1);
        drive(1'b1, 1'b0, 1'b1, 48'hA);
        tick();
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 48'hBAD);
        for (int i = 0; i < 3; i++) tick();
        idle(6);

        // Flush with five entries in flight and in_valid asserted on the flush edge.
        cfg_depth = 5'd8;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 48'(32'h100 + i));
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 48'hDEAD);
        tick();
        check_eq("flush_out_data", 64'(out_data), 64'h0);
        idle(8);
        check_eq("post_flush_out_data", 64'(out_data), 64'h0);

        // Depth change requested while busy waits for the drain.
        cfg_depth = 5'd10;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 48'(32'h200 + i));
            tick();
        end
        cfg_depth = 5'd3;
        idle(14);
        check_eq("drained_depth", 64'(depth), 64'd3);
        drive(1'b1, 1'b0, 1'b1, 48'h333);
        tick();
        idle(4);

        // Clamp at both ends.
        cfg_depth = 5'd0;
        idle(1);
        check_eq("clamp_low", 64'(depth), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 48'h77);
        tick();
        idle(2);
        cfg_depth = 5'd31;
        idle(1);
        check_eq("clamp_high", 64'(depth), 64'd28);

        // Continuous stream at depth 2, then reset mid-stream.
        cfg_depth = 5'd2;
        idle(1);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b0, 1'b1, 48'(i));
            tick();
        end
        rst = 1'b1;
        tick();
        check_eq("midrst_out_valid", 64'(out_valid), 64'h0);
        check_eq("midrst_depth", 64'(depth), 64'(RST_DEPTH));
        rst = 1'b0;
        idle(2);

        // Mixed random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            if (i % 37 == 0) cfg_depth = DEPTH_W'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 1) == 1, {16'($urandom), 32'($urandom)});
            tick();
        end
        idle(MAX_DEPTH + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
